rr_mux_arbiter: RTL

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//
// Four-requester round-robin arbiter with a burst-limited data multiplexer.
// The winner is chosen by searching upward from the slot after the last
// served requester, with wrap-around. A granted requester keeps the grant
// until it withdraws its request or completes MAX_BURST beats. On release
// the block re-arbitrates on the same edge, so continuously requesting
// masters are served back to back with no idle cycle between them.
//
// Handshake: a beat is transferred on every rising edge where
// out_valid==1 and ready==1. out_valid is combinational from the
// registered grant and the live request of the granted master. While
// ready==0 the grant, selection and beat count are held, and out_valid
// stays asserted as long as the granted master keeps requesting.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous, active-high reset
//   req[3:0]   : request per requester (bit i belongs to inp<i>)
//   inp0..inp3 : requester data, WIDTH bits each
//   ready      : downstream accepts the current beat
//   grant[3:0] : registered one-hot grant (all-zero when idle)
//   sel[1:0]   : registered index of the granted requester
//   out_valid  : out_data holds a valid beat
//   out_data   : data of the granted requester, zero when not valid
//
// The FSM state is held in the `state` register (IDLE/GRANT) so checkers
// can bind to it directly.
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] inp0,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic [WIDTH-1:0] inp3,
    input  logic             ready,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] last;
    logic [1:0] last_nxt;
    logic [1:0] sel_nxt;
    logic [3:0] grant_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    logic [1:0] search_base;
    logic [1:0] cand;
    logic [1:0] winner;
    logic       win_found;
    logic       beat;
    logic       rel;

    // ------------------------------------------------------------------
    // Output datapath
    // ------------------------------------------------------------------
    assign out_valid = (state == GRANT) && req[sel];
    assign beat      = out_valid && ready;

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (sel)
                2'd0:    out_data = inp0;
                2'd1:    out_data = inp1;
                2'd2:    out_data = inp2;
                default: out_data = inp3;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search
    // ------------------------------------------------------------------
    // A release updates last to sel on the same edge it re-arbitrates, so
    // in GRANT the search starts after sel; in IDLE it starts after last.
    assign search_base = (state == GRANT) ? sel : last;

    // Offsets 1..4 from the base; offset 4 wraps to the base itself so a
    // sole requester that just finished a burst wins again immediately.
    always_comb begin
        winner    = 2'd0;
        win_found = 1'b0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = search_base + 2'(k);
            if (!win_found && req[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    // Release on withdrawal, or on the beat that completes the burst.
    assign rel = (state == GRANT) && (!req[sel] || (beat && (cnt == LAST_BEAT)));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        sel_nxt   = sel;
        grant_nxt = grant;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = GRANT;
                    sel_nxt   = winner;
                    grant_nxt = 4'b0001 << winner;
                    cnt_nxt   = 4'd0;
                end
            end
            GRANT: begin
                if (rel) begin
                    last_nxt = sel;
                    cnt_nxt  = 4'd0;
                    if (win_found) begin
                        sel_nxt   = winner;
                        grant_nxt = 4'b0001 << winner;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = 4'b0000;
                    end
                end else if (beat) begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // last resets to 3 so the first search after reset starts at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= 4'b0000;
            sel   <= 2'b00;
            last  <= 2'b11;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            sel   <= sel_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule
